// File: rtl/can_tx_frame.sv
// can_tx_frame: CAN 2.0A base-frame transmitter (11-bit identifier).
// Serialises SOF..IFS on tx with bit stuffing and CRC-15. Each bit lasts BIT_DIV clocks.
// Optional build macro CAN_TX_ACK_CHECK_EN: samples rx in the ACK slot and flags
// ack_err when nobody drove the bus dominant. Without it, ack_err is tied low and rx is ignored.
module can_tx_frame #(
   parameter int BIT_DIV  = 4,
   parameter int IFS_BITS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [10:0] id,
   input  logic        rtr,
   input  logic [3:0]  dlc,
   input  logic [63:0] data,
   input  logic        rx,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic [14:0] crc_out
);

   localparam int              DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(BIT_DIV / 2);
   localparam logic [6:0]       IFS_LAST = 7'(IFS_BITS - 1);
   localparam logic [14:0]      CRC_POLY = 15'h4599;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SOF,
      ST_ARB,
      ST_CTRL,
      ST_DATA,
      ST_CRC,
      ST_CRC_DEL,
      ST_ACK,
      ST_ACK_DEL,
      ST_EOF,
      ST_IFS
   } state_t;

   state_t state;
   state_t state_nxt;

   // Frame fields captured when a start is accepted
   logic [10:0] id_l;
   logic        rtr_l;
   logic [3:0]  dlc_l;
   logic [63:0] data_l;

   // Bit timing and field position
   logic [DIV_W-1:0] div_cnt;
   logic [6:0]       bit_cnt;
   logic [6:0]       bit_cnt_nxt;
   logic [2:0]       run_cnt;
   logic [14:0]      crc;

   logic        accept;
   logic        bit_end;
   logic        in_stuff_zone;
   logic        stuff_now;
   logic        advance;
   logic        field_last;
   logic [6:0]  field_max;
   logic [3:0]  byte_cnt;
   logic [6:0]  data_bits;
   logic        next_bit;

   logic [11:0] arb_vec;
   logic [5:0]  ctrl_vec;
   logic [3:0]  arb_idx;
   logic [2:0]  ctrl_idx;
   logic [5:0]  data_idx;
   logic [3:0]  crc_idx;

   // One CRC-15 shift step for a single message bit
   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic fb;
      fb = b ^ c[14];
      crc_step = {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
   endfunction

   assign accept   = (state == ST_IDLE) && start;
   assign bit_end  = (state != ST_IDLE) && (div_cnt == DIV_LAST);
   assign byte_cnt = rtr_l ? 4'd0 : ((dlc_l > 4'd8) ? 4'd8 : dlc_l);
   assign data_bits = {byte_cnt, 3'b000};
   assign arb_vec  = {id_l, rtr_l};
   assign ctrl_vec = {2'b00, dlc_l};

   // state/bit_cnt name the last field bit put on the wire; a stuff bit leaves them
   // unchanged, so a run of 5 ending on the final CRC bit still gets its stuff bit
   // before CRC_DEL.
   assign in_stuff_zone = (state == ST_SOF) || (state == ST_ARB) || (state == ST_CTRL) ||
                          (state == ST_DATA) || (state == ST_CRC);
   assign stuff_now  = bit_end && in_stuff_zone && (run_cnt == 3'd5);
   assign advance    = bit_end && !stuff_now;
   assign field_last = (bit_cnt == field_max);

   // Index of the last bit in the current field
   always_comb begin
      field_max = '0;
      case (state)
         ST_SOF:     field_max = 7'd0;
         ST_ARB:     field_max = 7'd11;
         ST_CTRL:    field_max = 7'd5;
         ST_DATA:    field_max = data_bits - 7'd1;
         ST_CRC:     field_max = 7'd14;
         ST_CRC_DEL: field_max = 7'd0;
         ST_ACK:     field_max = 7'd0;
         ST_ACK_DEL: field_max = 7'd0;
         ST_EOF:     field_max = 7'd6;
         ST_IFS:     field_max = IFS_LAST;
         default:    field_max = 7'd0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and next field position: step on every non-stuff bit boundary
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      if (accept) begin
         state_nxt   = ST_SOF;
         bit_cnt_nxt = '0;
      end else if (advance) begin
         if (field_last) begin
            bit_cnt_nxt = '0;
            case (state)
               ST_SOF:     state_nxt = ST_ARB;
               ST_ARB:     state_nxt = ST_CTRL;
               ST_CTRL:    state_nxt = (byte_cnt == 4'd0) ? ST_CRC : ST_DATA;
               ST_DATA:    state_nxt = ST_CRC;
               ST_CRC:     state_nxt = ST_CRC_DEL;
               ST_CRC_DEL: state_nxt = ST_ACK;
               ST_ACK:     state_nxt = ST_ACK_DEL;
               ST_ACK_DEL: state_nxt = ST_EOF;
               ST_EOF:     state_nxt = ST_IFS;
               ST_IFS:     state_nxt = ST_IDLE;
               default:    state_nxt = ST_IDLE;
            endcase
         end else begin
            bit_cnt_nxt = bit_cnt + 7'd1;
         end
      end
   end

   // Outputs: status flags and the value of the next field bit
   always_comb begin
      busy     = (state != ST_IDLE);
      done     = (state == ST_IFS) && advance && field_last;
      arb_idx  = 4'd11 - bit_cnt_nxt[3:0];
      ctrl_idx = 3'd5 - bit_cnt_nxt[2:0];
      data_idx = 6'd63 - bit_cnt_nxt[5:0];
      crc_idx  = 4'd14 - bit_cnt_nxt[3:0];
      next_bit = 1'b1;
      case (state_nxt)
         ST_SOF:  next_bit = 1'b0;
         ST_ARB:  next_bit = arb_vec[arb_idx];
         ST_CTRL: next_bit = ctrl_vec[ctrl_idx];
         ST_DATA: next_bit = data_l[data_idx];
         ST_CRC:  next_bit = crc[crc_idx];
         default: next_bit = 1'b1;
      endcase
   end

   // Capture the frame fields when a start is accepted; held for the whole frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_l   <= '0;
         rtr_l  <= 1'b0;
         dlc_l  <= '0;
         data_l <= '0;
      end else if (accept) begin
         id_l   <= id;
         rtr_l  <= rtr;
         dlc_l  <= dlc;
         data_l <= data;
      end
   end

   // Bit timing, tx shifting, stuffing run length and CRC accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         run_cnt <= '0;
         crc     <= '0;
         crc_out <= '0;
         tx      <= 1'b1;
      end else if (accept) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         run_cnt <= 3'd1;
         crc     <= '0;
         tx      <= 1'b0;
      end else if (state != ST_IDLE) begin
         if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt_nxt;
            if (stuff_now) begin
               tx      <= ~tx;
               run_cnt <= 3'd1;
            end else begin
               tx <= next_bit;
               if (next_bit == tx) begin
                  run_cnt <= (run_cnt == 3'd5) ? 3'd5 : run_cnt + 3'd1;
               end else begin
                  run_cnt <= 3'd1;
               end
               // SOF is always 0 and contributes nothing from a zero seed
               if ((state_nxt == ST_ARB) || (state_nxt == ST_CTRL) || (state_nxt == ST_DATA)) begin
                  crc <= crc_step(crc, next_bit);
               end
               if ((state_nxt == ST_CRC) && (state != ST_CRC)) begin
                  crc_out <= crc;
               end
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

`ifdef CAN_TX_ACK_CHECK_EN
   // Sample the bus mid ACK bit; recessive means no receiver acknowledged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_err <= 1'b0;
      end else if (accept) begin
         ack_err <= 1'b0;
      end else if ((state == ST_ACK) && (div_cnt == DIV_MID) && rx) begin
         ack_err <= 1'b1;
      end
   end
`else
   logic unused_rx;
   assign unused_rx = rx;
   assign ack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_frame.sv
// tb_can_tx_frame: directed frames for can_tx_frame with a scoreboard.
// Stimulus pushes the expected frame; a monitor captures tx, destuffs it and
// checks stream, CRC, stuff count, busy length and ack_err at each done pulse.
module tb_can_tx_frame;

   localparam int BD  = 4;
   localparam int IFS = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [10:0] id = '0;
   logic        rtr = 1'b0;
   logic [3:0]  dlc = '0;
   logic [63:0] data = '0;
   logic        rx = 1'b1;
   logic        tx;
   logic        busy;
   logic        done;
   logic        ack_err;
   logic [14:0] crc_out;

   can_tx_frame #(.BIT_DIV(BD), .IFS_BITS(IFS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .id(id), .rtr(rtr), .dlc(dlc),
      .data(data), .rx(rx), .tx(tx), .busy(busy), .done(done), .ack_err(ack_err),
      .crc_out(crc_out)
   );

   always #5 clk = ~clk;

   // Directed vectors; hand values (crc, stuff count) where -1 means use the model
   localparam logic [10:0] V_ID   [8] = '{11'h000, 11'h7FF, 11'h123, 11'h555,
                                          11'h2AA, 11'h0F0, 11'h400, 11'h3FF};
   localparam logic        V_RTR  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [3:0]  V_DLC  [8] = '{4'd0, 4'd8, 4'd8, 4'd3, 4'd15, 4'd1, 4'd2, 4'd4};
   localparam logic [63:0] V_DATA [8] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                                          64'hA55A_FF00_0000_0000, 64'hDEAD_BEEF_CAFE_F00D,
                                          64'h3C00_0000_0000_0000, 64'h8001_0000_0000_0000, 64'h0};
   localparam logic        V_RX   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam int          V_HCRC [8] = '{0, -1, -1, -1, -1, -1, -1, -1};
   localparam int          V_HST  [8] = '{6, -1, -1, -1, -1, -1, -1, -1};

   typedef struct {
      logic [127:0] bits;
      int           n;
      int           l;
      int           stuffs;
      logic [14:0]  crc;
      logic         ack;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   int frames_done = 0;
   int last_gap = 0;
   int idle_cnt = 0;
   logic idle_tx_bad = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Reference frame: unstuffed bit list, CRC and stuff count
   function automatic exp_t build_exp(input int vi);
      exp_t e;
      int k;
      int nb;
      int run;
      int st;
      logic prev;
      logic fb;
      logic [14:0] c;
      e.bits = '0;
      k = 0;
      nb = V_RTR[vi] ? 0 : ((V_DLC[vi] > 4'd8) ? 8 : int'(V_DLC[vi]));
      e.bits[k] = 1'b0; k++;
      for (int i = 10; i >= 0; i--) begin e.bits[k] = V_ID[vi][i]; k++; end
      e.bits[k] = V_RTR[vi]; k++;
      e.bits[k] = 1'b0; k++;
      e.bits[k] = 1'b0; k++;
      for (int i = 3; i >= 0; i--) begin e.bits[k] = V_DLC[vi][i]; k++; end
      for (int i = 63; i >= 64 - 8 * nb; i--) begin e.bits[k] = V_DATA[vi][i]; k++; end
      c = '0;
      for (int i = 0; i < k; i++) begin
         fb = e.bits[i] ^ c[14];
         c = {c[13:0], 1'b0};
         if (fb) c = c ^ 15'h4599;
      end
      for (int i = 14; i >= 0; i--) begin e.bits[k] = c[i]; k++; end
      e.l = k;
      for (int i = 0; i < 10 + IFS; i++) begin e.bits[k] = 1'b1; k++; end
      e.n = k;
      run = 1;
      prev = e.bits[0];
      st = 0;
      for (int i = 1; i < e.l; i++) begin
         if (run == 5) begin st++; prev = ~prev; run = 1; end
         if (e.bits[i] == prev) run++; else run = 1;
         prev = e.bits[i];
      end
      if (run == 5) st++;
      e.crc = (V_HCRC[vi] >= 0) ? 15'(V_HCRC[vi]) : c;
      e.stuffs = (V_HST[vi] >= 0) ? V_HST[vi] : st;
`ifdef CAN_TX_ACK_CHECK_EN
      e.ack = V_RX[vi];
`else
      e.ack = 1'b0;
`endif
      return e;
   endfunction

   // Monitor: capture mid-bit tx samples, destuff and score at each done
   int cyc = 0;
   int raw_n = 0;
   logic [255:0] raw = '0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      logic [127:0] dec;
      int u;
      int run;
      int st;
      int perr;
      logic prv;
      logic b;
      if (busy && !prev_busy) begin
         last_gap = idle_cnt;
         cyc = 0;
         raw_n = 0;
         raw = '0;
      end
      if (busy) begin
         idle_cnt = 0;
         if ((cyc % BD) == 1 && raw_n < 256) begin
            raw[raw_n] = tx;
            raw_n++;
         end
         cyc++;
      end else begin
         idle_cnt++;
         if (rst_n && tx !== 1'b1) idle_tx_bad = 1'b1;
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 128'(done), 128'(0));
         end else begin
            e = exp_q.pop_front();
            dec = '0; u = 0; run = 0; st = 0; perr = 0; prv = 1'b0;
            for (int i = 0; i < raw_n; i++) begin
               b = raw[i];
               if (run == 5 && u <= e.l) begin
                  if (b == prv) perr++;
                  st++;
                  run = 1;
                  prv = b;
               end else begin
                  run = (u > 0 && b == prv) ? run + 1 : 1;
                  if (u < 128) dec[u] = b;
                  u++;
                  prv = b;
               end
            end
            check("crc_out", 128'(crc_out), 128'(e.crc));
            check("ack_err", 128'(ack_err), 128'(e.ack));
            check("unstuffed_len", 128'(u), 128'(e.n));
            check("frame_bits", dec, e.bits);
            check("stuff_count", 128'(st), 128'(e.stuffs));
            check("stuff_polarity_errs", 128'(perr), 128'(0));
            check("busy_cycles", 128'(cyc), 128'((e.n + e.stuffs) * BD));
         end
         frames_done++;
      end
      prev_busy = busy;
   end

   task automatic drive_vec(input int vi);
      id = V_ID[vi];
      rtr = V_RTR[vi];
      dlc = V_DLC[vi];
      data = V_DATA[vi];
      rx = V_RX[vi];
   endtask

   task automatic issue(input int vi, input bit rel, input bit push);
      @(negedge clk);
      drive_vec(vi);
      if (rel) rst_n = 1'b1;
      start = 1'b1;
      if (push) exp_q.push_back(build_exp(vi));
      @(posedge clk);
      #1;
      check("accept_busy", 128'(busy), 128'(1));
      check("sof_tx", 128'(tx), 128'(0));
      start = 1'b0;
   endtask

   task automatic poke_busy();
      repeat (20) @(negedge clk);
      id = ~id;
      rtr = ~rtr;
      dlc = ~dlc;
      data = ~data;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int g;
      g = 0;
      while (frames_done < target && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("frames_done", 128'(frames_done), 128'(target));
   endtask

   task automatic wait_busy(input logic lvl, input string name);
      int g;
      g = 0;
      while (busy !== lvl && g < 50) begin
         @(negedge clk);
         g++;
      end
      check(name, 128'(busy), 128'(lvl));
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 128'(tx), 128'(1));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_ack_err", 128'(ack_err), 128'(0));
      check("rst_crc_out", 128'(crc_out), 128'(0));

      issue(0, 1'b1, 1'b1);
      wait_frames(1);
      issue(1, 1'b0, 1'b1);
      poke_busy();
      wait_frames(2);
      issue(2, 1'b0, 1'b1);
      wait_frames(3);

      // Abort in the data field: no done may follow
      issue(3, 1'b0, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      check("abort_busy_before", 128'(busy), 128'(1));
      rst_n = 1'b0;
      #1;
      check("abort_tx", 128'(tx), 128'(1));
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_done", 128'(done), 128'(0));
      repeat (2) @(negedge clk);
      issue(4, 1'b1, 1'b1);
      wait_frames(4);
      issue(5, 1'b0, 1'b1);
      wait_frames(5);

      // Start held high: second frame latches the fields present at its accept
      @(negedge clk);
      drive_vec(6);
      start = 1'b1;
      exp_q.push_back(build_exp(6));
      @(posedge clk);
      #1;
      check("b2b_accept1", 128'(busy), 128'(1));
      repeat (10) @(negedge clk);
      drive_vec(7);
      exp_q.push_back(build_exp(7));
      wait_frames(6);
      wait_busy(1'b0, "b2b_idle");
      wait_busy(1'b1, "b2b_accept2");
      start = 1'b0;
      wait_frames(7);
      check("b2b_gap_cycles", 128'(last_gap), 128'(1));

      repeat (5) @(negedge clk);
      check("queue_empty", 128'(exp_q.size()), 128'(0));
      check("idle_tx_recessive", 128'(idle_tx_bad), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
